// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pattern-mode encodings.
// Defaults describe the standard 640x480@60 raster (25.175 MHz pixel clock).
package vga_pkg;

    // Sum of the four segments of one scan direction (active, porches, sync).
    function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Default horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Counter width must hold H_TOTAL-1 and V_TOTAL-1.
    localparam int DEF_CNT_W = 11;

    // Border thickness of the border test pattern, in pixels.
    localparam int DEF_PAT_BORDER = 10;

    // Test pattern selection, as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_BORDER  = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BLACK   = 2'd3
    } mode_e;

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern decode: pixel coordinate plus mode to 1-bit rgb.
// Blanking is applied by the caller; this block colours every coordinate.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int PAT_BORDER = DEF_PAT_BORDER,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic [CNT_W-1:0] x_i,
    input  logic [CNT_W-1:0] y_i,
    input  mode_e            mode_i,
    output logic [2:0]       rgb_o
);

    // Product width for x*8 so the bar index division cannot overflow.
    localparam int PW = CNT_W + 3;

    localparam logic [CNT_W-1:0] BORDER_LO = CNT_W'(PAT_BORDER);
    localparam logic [CNT_W-1:0] G_EDGE    = CNT_W'(H_ACTIVE - PAT_BORDER);
    localparam logic [CNT_W-1:0] B_EDGE    = CNT_W'(V_ACTIVE - PAT_BORDER);
    localparam logic [PW-1:0]    BAR_DIV   = PW'(H_ACTIVE);

    logic [2:0] bar_idx;

    // Eight equal-width bars: index = x*8/H_ACTIVE, divisor is a constant.
    always_comb begin
        bar_idx = 3'(({x_i, 3'b000}) / BAR_DIV);
    end

    // Select the colour of the requested pattern at (x_i, y_i).
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rgb_o = 3'b000;
        case (mode_i)
            MODE_BORDER: begin
                rgb_o[2] = (x_i < BORDER_LO);
                rgb_o[1] = (x_i >= G_EDGE);
                rgb_o[0] = (y_i < BORDER_LO) || (y_i >= B_EDGE);
            end
            MODE_BARS:    rgb_o = 3'd7 - bar_idx;
            MODE_CHECKER: rgb_o = {3{x_i[5] ^ y_i[5]}};
            default:      rgb_o = 3'b000;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with built-in test pattern.
// Raster counters advance on pix_en ticks; every output is registered from the
// pre-increment counters so coordinates, syncs, de and colour stay aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PAT_BORDER = DEF_PAT_BORDER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [1:0]       mode,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             r,
    output logic             g,
    output logic             b
);

    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Raster position of the pixel about to be emitted.
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Pattern mode, frozen for the whole frame.
    mode_e mode_q, mode_d;

    // Registered outputs and their decoded next values.
    logic [CNT_W-1:0] x_q, y_q;
    logic             de_q, de_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic       frame_top;
    logic [2:0] pat_rgb;

    assign frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Raster counters: h wraps at the end of the line and carries into v.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Mode is sampled only on the tick that emits pixel (0,0), and that pixel
    // already uses the new mode, so a frame is always drawn in one pattern.
    always_comb begin
        mode_d = mode_q;
        if (pix_en && frame_top) begin
            mode_d = mode_e'(mode);
        end
    end

    vga_pattern #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .PAT_BORDER (PAT_BORDER),
        .CNT_W      (CNT_W)
    ) u_pattern (
        .x_i    (h_cnt_q),
        .y_i    (v_cnt_q),
        .mode_i (mode_d),
        .rgb_o  (pat_rgb)
    );

    // Decode syncs, data-enable, blanked colour and the start pulses from the
    // current counters; pulses are qualified by pix_en so they last one clock.
    always_comb begin
        de_d          = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END)) ? VS_POL : ~VS_POL;
        rgb_d         = de_d ? pat_rgb : 3'b000;
        line_start_d  = pix_en && (h_cnt_q == '0);
        frame_start_d = pix_en && frame_top;
    end

    // State and output registers; display outputs load only on pixel ticks.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_q        <= MODE_BORDER;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            rgb_q         <= 3'b000;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_q        <= mode_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (pix_en) begin
                x_q     <= h_cnt_q;
                y_q     <= v_cnt_q;
                de_q    <= de_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                rgb_q   <= rgb_d;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign r           = rgb_q[2];
    assign g           = rgb_q[1];
    assign b           = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 640x480, a small
// raster for frame-level behaviour, and 800x600 with active-high syncs) share
// clock, reset, pix_en and mode. Expected outputs come from a pixel-index model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, border;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        de, hs, vs, ls, fs;
        logic [2:0]  rgb;
    } out_t;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 10, 1'b0, 1'b0};
    cfg_t cfg_s = '{80, 4, 8, 8, 60, 2, 2, 3, 10, 1'b0, 1'b0};
    cfg_t cfg_w = '{800, 40, 128, 88, 600, 1, 4, 23, 10, 1'b1, 1'b1};

    localparam longint FRAME_A = 800 * 525;
    localparam longint FRAME_S = 100 * 67;
    localparam longint FRAME_W = 1056 * 628;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [1:0] mode = 2'd0;

    logic [10:0] xa, ya, xs, ys, xw, yw;
    logic hsa, vsa, dea, lsa, fsa, ra, ga, ba;
    logic hss, vss, des, lss, fss, rs, gs, bs;
    logic hsw, vsw, dew, lsw, fsw, rw, gw, bw;

    out_t got_a, got_s, got_w;
    assign got_a = {xa, ya, dea, hsa, vsa, lsa, fsa, ra, ga, ba};
    assign got_s = {xs, ys, des, hss, vss, lss, fss, rs, gs, bs};
    assign got_w = {xw, yw, dew, hsw, vsw, lsw, fsw, rw, gw, bw};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode),
        .hsync(hsa), .vsync(vsa), .de(dea), .x(xa), .y(ya),
        .line_start(lsa), .frame_start(fsa), .r(ra), .g(ga), .b(ba)
    );

    vga_timing_gen #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode),
        .hsync(hss), .vsync(vss), .de(des), .x(xs), .y(ys),
        .line_start(lss), .frame_start(fss), .r(rs), .g(gs), .b(bs)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode(mode),
        .hsync(hsw), .vsync(vsw), .de(dew), .x(xw), .y(yw),
        .line_start(lsw), .frame_start(fsw), .r(rw), .g(gw), .b(bw)
    );

    // Bench bookkeeping of its own stimulus: number of pixel ticks since reset,
    // whether the last edge was a tick, and the mode each raster captured at its
    // most recent frame start.
    longint ticks;
    bit     tick_last;
    mode_e  fm_a, fm_s, fm_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks     <= 0;
            tick_last <= 1'b0;
            fm_a      <= MODE_BORDER;
            fm_s      <= MODE_BORDER;
            fm_w      <= MODE_BORDER;
        end else begin
            tick_last <= pix_en;
            if (pix_en) begin
                ticks <= ticks + 1;
                if (ticks % FRAME_A == 0) fm_a <= mode_e'(mode);
                if (ticks % FRAME_S == 0) fm_s <= mode_e'(mode);
                if (ticks % FRAME_W == 0) fm_w <= mode_e'(mode);
            end
        end
    end

    // Expected outputs after t ticks: the t-th emitted pixel (index t-1 in raster
    // order) with syncs, de and colour derived from the timing rules.
    function automatic out_t model(input longint t, input bit tl, input mode_e fm, input cfg_t c);
        out_t   o;
        int     ht;
        int     vt;
        longint idx;
        int     px;
        int     py;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        o = '{x: '0, y: '0, de: 1'b0, hs: !c.hpol, vs: !c.vpol, ls: 1'b0, fs: 1'b0, rgb: 3'b000};
        if (t == 0) return o;
        idx  = (t - 1) % longint'(ht * vt);
        px   = int'(idx % ht);
        py   = int'(idx / ht);
        o.x  = 11'(px);
        o.y  = 11'(py);
        o.de = (px < c.ha) && (py < c.va);
        o.hs = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
        o.vs = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
        o.ls = tl && (px == 0);
        o.fs = tl && (px == 0) && (py == 0);
        if (o.de) begin
            case (fm)
                MODE_BORDER:  o.rgb = {px < c.border, px >= c.ha - c.border,
                                       (py < c.border) || (py >= c.va - c.border)};
                MODE_BARS:    o.rgb = 3'(7 - (px * 8) / c.ha);
                MODE_CHECKER: o.rgb = {3{1'(((px / 32) + (py / 32)) % 2)}};
                default:      o.rgb = 3'b000;
            endcase
        end
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'($urandom);
            mode   = 2'($urandom);
            @(negedge clk);
            checks++;
            if (hsa !== 1'b1 || vsa !== 1'b1 || dea !== 1'b0 || {ra, ga, ba} !== 3'b000 ||
                xa !== 11'd0 || ya !== 11'd0 || lsa !== 1'b0 || fsa !== 1'b0) begin
                errors++;
                $display("FAIL reset_a got=%h required x=0 y=0 de=0 hs=1 vs=1 rgb=0", got_a);
            end
            checks++;
            if (hsw !== 1'b0 || vsw !== 1'b0 || dew !== 1'b0 || {rw, gw, bw} !== 3'b000) begin
                errors++;
                $display("FAIL reset_w got=%h required hs=0 vs=0 de=0 rgb=0", got_w);
            end
        end
        mode   = 2'd0;
        pix_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (fsa !== 1'b1 || lsa !== 1'b1 || xa !== 11'd0 || ya !== 11'd0 || dea !== 1'b1 ||
            {ra, ga, ba} !== 3'b101) begin
            errors++;
            $display("FAIL first_tick got=%h required x=0 y=0 de=1 ls=1 fs=1 rgb=101", got_a);
        end
        @(negedge clk);
        checks++;
        if (fsa !== 1'b0 || lsa !== 1'b0 || xa !== 11'd1) begin
            errors++;
            $display("FAIL second_tick got=%h required x=1 ls=0 fs=0", got_a);
        end
    endtask

    task automatic test_line_timing();
        out_t e;
        int   last_a = -1, last_w = -1;
        int   hs_min = 9999, hs_max = -1, de_max = -1, w_min = 9999, w_max = -1;
        pix_en = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            e = model(ticks, tick_last, fm_a, cfg_a);
            checks++;
            if (got_a !== e) begin
                errors++;
                $display("FAIL line_a t=%0t got=%h required=%h", $time, got_a, e);
            end
            e = model(ticks, tick_last, fm_w, cfg_w);
            checks++;
            if (got_w !== e) begin
                errors++;
                $display("FAIL line_w t=%0t got=%h required=%h", $time, got_w, e);
            end
            if (hsa === 1'b0) begin
                if (int'(xa) < hs_min) hs_min = int'(xa);
                if (int'(xa) > hs_max) hs_max = int'(xa);
            end
            if (dea === 1'b1 && int'(xa) > de_max) de_max = int'(xa);
            if (hsw === 1'b1) begin
                if (int'(xw) < w_min) w_min = int'(xw);
                if (int'(xw) > w_max) w_max = int'(xw);
            end
            if (lsa === 1'b1) begin
                if (last_a >= 0) begin
                    checks++;
                    if (i - last_a != 800) begin
                        errors++;
                        $display("FAIL line_period_a got=%0d required=800", i - last_a);
                    end
                end
                last_a = i;
            end
            if (lsw === 1'b1) begin
                if (last_w >= 0) begin
                    checks++;
                    if (i - last_w != 1056) begin
                        errors++;
                        $display("FAIL line_period_w got=%0d required=1056", i - last_w);
                    end
                end
                last_w = i;
            end
        end
        checks++;
        if (hs_min != 656 || hs_max != 751) begin
            errors++;
            $display("FAIL hsync_range_a got=%0d..%0d required=656..751", hs_min, hs_max);
        end
        checks++;
        if (de_max != 639) begin
            errors++;
            $display("FAIL de_range_a got_max=%0d required=639", de_max);
        end
        checks++;
        if (w_min != 840 || w_max != 967) begin
            errors++;
            $display("FAIL hsync_range_w got=%0d..%0d required=840..967", w_min, w_max);
        end
    endtask

    task automatic test_frame();
        out_t e;
        int   last_f = -1, periods = 0, vs_min = 9999, vs_max = -1;
        logic [10:0] px = '0, py = '0;
        pix_en = 1'b1;
        for (int i = 0; i < 15000 && periods < 1; i++) begin
            @(negedge clk);
            e = model(ticks, tick_last, fm_s, cfg_s);
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL frame_s t=%0t got=%h required=%h", $time, got_s, e);
            end
            if (vss === 1'b0) begin
                if (int'(ys) < vs_min) vs_min = int'(ys);
                if (int'(ys) > vs_max) vs_max = int'(ys);
            end
            if (fss === 1'b1) begin
                checks++;
                if (px !== 11'd99 || py !== 11'd66) begin
                    errors++;
                    $display("FAIL wrap_s got_prev=(%0d,%0d) required=(99,66)", px, py);
                end
                if (last_f >= 0) begin
                    periods++;
                    checks++;
                    if (i - last_f != 6700) begin
                        errors++;
                        $display("FAIL frame_period_s got=%0d required=6700", i - last_f);
                    end
                end
                last_f = i;
            end
            px = xs;
            py = ys;
        end
        checks++;
        if (periods < 1) begin
            errors++;
            $display("FAIL frame_timeout_s got_periods=%0d required=1", periods);
        end
        checks++;
        if (vs_min != 62 || vs_max != 63) begin
            errors++;
            $display("FAIL vsync_range_s got=%0d..%0d required=62..63", vs_min, vs_max);
        end
    endtask

    task automatic test_pix_en_toggle();
        out_t e;
        int   last_l = -1;
        logic prev_ls = 1'b0;
        logic [10:0] prev_x = '0;
        logic [2:0]  prev_rgb = '0;
        for (int i = 0; i < 1000; i++) begin
            pix_en = (i % 2 == 0);
            @(negedge clk);
            e = model(ticks, tick_last, fm_s, cfg_s);
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL toggle_s t=%0t got=%h required=%h", $time, got_s, e);
            end
            if (i > 0 && !tick_last) begin
                checks++;
                if (xs !== prev_x || {rs, gs, bs} !== prev_rgb) begin
                    errors++;
                    $display("FAIL hold_s got x=%0d rgb=%b required x=%0d rgb=%b", xs, {rs, gs, bs}, prev_x, prev_rgb);
                end
            end
            if (lss === 1'b1) begin
                checks++;
                if (prev_ls === 1'b1) begin
                    errors++;
                    $display("FAIL pulse_width_s got=2+ clk required=1 clk");
                end
                if (last_l >= 0) begin
                    checks++;
                    if (i - last_l != 200) begin
                        errors++;
                        $display("FAIL toggle_line_period_s got=%0d required=200", i - last_l);
                    end
                end
                last_l = i;
            end
            prev_ls  = lss;
            prev_x   = xs;
            prev_rgb = {rs, gs, bs};
        end
    endtask

    task automatic test_mode_change();
        out_t e;
        bit   found = 1'b0, seen_border = 1'b0, seen_chk = 1'b0;
        pix_en = 1'b1;
        mode   = 2'd0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            found = (ys == 11'd40);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_y40_s got_y=%0d required=40", ys);
        end
        mode  = 2'd2;
        found = 1'b0;
        for (int i = 0; i < 8000 && !seen_chk; i++) begin
            @(negedge clk);
            e = model(ticks, tick_last, fm_s, cfg_s);
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL mode_s t=%0t got=%h required=%h", $time, got_s, e);
            end
            if (fss === 1'b1) found = 1'b1;
            if (!found && xs == 11'd5 && ys == 11'd50) begin
                seen_border = 1'b1;
                checks++;
                if ({rs, gs, bs} !== 3'b101) begin
                    errors++;
                    $display("FAIL border_kept_s got=%b required=101", {rs, gs, bs});
                end
            end
            if (found && xs == 11'd32 && ys == 11'd0) begin
                seen_chk = 1'b1;
                checks++;
                if ({rs, gs, bs} !== 3'b111) begin
                    errors++;
                    $display("FAIL checker_32_0_s got=%b required=111", {rs, gs, bs});
                end
            end
        end
        checks++;
        if (!seen_border || !seen_chk) begin
            errors++;
            $display("FAIL mode_timeout_s got border=%0b checker=%0b required 1 1", seen_border, seen_chk);
        end
    endtask

    task automatic test_random();
        out_t e;
        for (int i = 0; i < 4000; i++) begin
            pix_en = ($urandom % 4) != 0;
            if (i % 500 == 0) mode = 2'($urandom);
            @(negedge clk);
            e = model(ticks, tick_last, fm_a, cfg_a);
            checks++;
            if (got_a !== e) begin
                errors++;
                $display("FAIL rand_a t=%0t got=%h required=%h", $time, got_a, e);
            end
            e = model(ticks, tick_last, fm_s, cfg_s);
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL rand_s t=%0t got=%h required=%h", $time, got_s, e);
            end
            e = model(ticks, tick_last, fm_w, cfg_w);
            checks++;
            if (got_w !== e) begin
                errors++;
                $display("FAIL rand_w t=%0t got=%h required=%h", $time, got_w, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t e;
        pix_en = 1'b1;
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (xs !== 11'd0 || ys !== 11'd0 || hss !== 1'b1 || vss !== 1'b1 || des !== 1'b0 ||
            {rs, gs, bs} !== 3'b000 || lss !== 1'b0 || fss !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_s got=%h required x=0 y=0 de=0 hs=1 vs=1 rgb=0", got_s);
        end
        checks++;
        if (hsw !== 1'b0 || vsw !== 1'b0 || xw !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_w got=%h required hs=0 vs=0 x=0", got_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fss !== 1'b1 || xs !== 11'd0 || ys !== 11'd0 || des !== 1'b1) begin
            errors++;
            $display("FAIL restart_s got=%h required x=0 y=0 de=1 fs=1", got_s);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = model(ticks, tick_last, fm_w, cfg_w);
            checks++;
            if (got_w !== e) begin
                errors++;
                $display("FAIL restart_w t=%0t got=%h required=%h", $time, got_w, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_pix_en_toggle();
        test_mode_change();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
